// File: rtl/fb_scaler_display.sv
// fb_scaler_display: video timing generator with per-line framebuffer fetch,
// integer pixel upscaling, optional cell grid and double-buffered bank swap.
module fb_scaler_display #(
  parameter int unsigned BUF_W = 32,
  parameter int unsigned BUF_H = 32,
  parameter int unsigned SCALE = 22,
  parameter int unsigned GRID  = 1,
  localparam int unsigned TW   = 12,
  localparam int unsigned AW   = (BUF_H > 1) ? $clog2(BUF_H) : 1
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst,
  input  logic [TW-1:0]    I_h_total,
  input  logic [TW-1:0]    I_h_sync,
  input  logic [TW-1:0]    I_h_bporch,
  input  logic [TW-1:0]    I_h_res,
  input  logic [TW-1:0]    I_v_total,
  input  logic [TW-1:0]    I_v_sync,
  input  logic [TW-1:0]    I_v_bporch,
  input  logic [TW-1:0]    I_v_res,
  input  logic             I_hs_pol,
  input  logic             I_vs_pol,
  input  logic [23:0]      I_on_rgb,
  input  logic [23:0]      I_off_rgb,
  input  logic [23:0]      I_bg_rgb,
  input  logic             I_swap_req,
  output logic             O_swap_ack,
  output logic             O_front_bank,
  output logic             O_fb_rd,
  output logic             O_fb_bank,
  output logic [AW-1:0]    O_fb_addr,
  input  logic [BUF_W-1:0] I_fb_row,
  output logic             O_de,
  output logic             O_hs,
  output logic             O_vs,
  output logic [7:0]       O_data_r,
  output logic [7:0]       O_data_g,
  output logic [7:0]       O_data_b
);

  localparam logic [TW-1:0] IMG_W  = TW'(BUF_W * SCALE);
  localparam logic [TW-1:0] IMG_H  = TW'(BUF_H * SCALE);
  localparam logic [7:0]    SC_MAX = 8'(SCALE - 1);

  logic [TW-1:0]    r_h, r_v, r_col, r_row;
  logic [7:0]       r_sub_h, r_sub_v;
  logic [BUF_W-1:0] r_line;
  logic             r_pend, r_rd_q;
  logic             r_de1, r_hs1, r_vs1;
  logic [23:0]      r_rgb1;

  logic [TW-1:0]    w_h_start, w_v_start, w_hx, w_vy, w_h_next, w_v_next, w_vy_next;
  logic             w_h_last, w_v_last, w_h_act, w_v_act, w_h_img, w_v_img;
  logic             w_fetch, w_swap;
  logic [TW-1:0]    w_col_n, w_row_n;
  logic [7:0]       w_sub_h_n, w_sub_v_n;
  logic [BUF_W-1:0] w_shift;
  logic [23:0]      w_rgb;

  // Raster position, active/image windows, next-line fetch and swap decision
  always_comb begin
    w_h_start = I_h_sync + I_h_bporch;
    w_v_start = I_v_sync + I_v_bporch;
    w_h_last  = (r_h == I_h_total - TW'(1));
    w_v_last  = (r_v == I_v_total - TW'(1));
    w_h_next  = w_h_last ? '0 : r_h + TW'(1);
    w_v_next  = !w_h_last ? r_v : (w_v_last ? '0 : r_v + TW'(1));
    w_hx      = r_h - w_h_start;
    w_vy      = r_v - w_v_start;
    w_vy_next = w_v_next - w_v_start;
    w_h_act   = (r_h >= w_h_start) && (w_hx < I_h_res);
    w_v_act   = (r_v >= w_v_start) && (w_vy < I_v_res);
    w_h_img   = w_h_act && (w_hx < IMG_W);
    w_v_img   = w_v_act && (w_vy < IMG_H);
    // Strobe is registered, so it is decided on the last pixel of the previous line
    w_fetch   = w_h_last && (w_v_next >= w_v_start) &&
                (w_vy_next < I_v_res) && (w_vy_next < IMG_H);
    w_swap    = (r_h == '0) && (r_v == '0) && (r_pend || I_swap_req);
  end

  // Cell position tracking without a divider
  always_comb begin
    w_sub_h_n = r_sub_h;
    w_col_n   = r_col;
    if (w_h_next == w_h_start) begin
      w_sub_h_n = '0;
      w_col_n   = '0;
    end else if (w_h_act) begin
      if (r_sub_h == SC_MAX) begin
        w_sub_h_n = '0;
        w_col_n   = r_col + TW'(1);
      end else begin
        w_sub_h_n = r_sub_h + 8'd1;
      end
    end
    w_sub_v_n = r_sub_v;
    w_row_n   = r_row;
    if (w_h_last) begin
      if (w_v_next == w_v_start) begin
        w_sub_v_n = '0;
        w_row_n   = '0;
      end else if (w_v_act) begin
        if (r_sub_v == SC_MAX) begin
          w_sub_v_n = '0;
          w_row_n   = r_row + TW'(1);
        end else begin
          w_sub_v_n = r_sub_v + 8'd1;
        end
      end
    end
  end

  // Pixel colour selection; leftmost pixel lives in the MSB of the line register
  always_comb begin
    w_shift = r_line << r_col;
    w_rgb   = '0;
    if (w_h_act && w_v_act) begin
      if (!(w_h_img && w_v_img))                           w_rgb = I_bg_rgb;
      else if ((GRID != 0) && (r_sub_h == '0 || r_sub_v == '0)) w_rgb = '0;
      else if (w_shift[BUF_W-1])                           w_rgb = I_on_rgb;
      else                                                 w_rgb = I_off_rgb;
    end
  end

  // Counters, line fetch/capture and bank swap handshake
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_h          <= '0;
      r_v          <= '0;
      r_sub_h      <= '0;
      r_sub_v      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_line       <= '0;
      r_rd_q       <= 1'b0;
      r_pend       <= 1'b0;
      O_fb_rd      <= 1'b0;
      O_fb_addr    <= '0;
      O_fb_bank    <= 1'b0;
      O_front_bank <= 1'b0;
      O_swap_ack   <= 1'b0;
    end else begin
      r_h     <= w_h_next;
      r_v     <= w_v_next;
      r_sub_h <= w_sub_h_n;
      r_sub_v <= w_sub_v_n;
      r_col   <= w_col_n;
      r_row   <= w_row_n;
      O_fb_rd <= w_fetch;
      if (w_fetch) begin
        O_fb_addr <= AW'(w_row_n);
        O_fb_bank <= O_front_bank;
      end
      r_rd_q <= O_fb_rd;
      if (r_rd_q) r_line <= I_fb_row;
      r_pend       <= !w_swap && (r_pend || I_swap_req);
      O_front_bank <= O_front_bank ^ w_swap;
      O_swap_ack   <= w_swap;
    end
  end

  // Two-stage output pipeline
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_de1    <= 1'b0;
      r_hs1    <= ~I_hs_pol;
      r_vs1    <= ~I_vs_pol;
      r_rgb1   <= '0;
      O_de     <= 1'b0;
      O_hs     <= ~I_hs_pol;
      O_vs     <= ~I_vs_pol;
      O_data_r <= '0;
      O_data_g <= '0;
      O_data_b <= '0;
    end else begin
      r_de1    <= w_h_act && w_v_act;
      r_hs1    <= (r_h < I_h_sync) ? I_hs_pol : ~I_hs_pol;
      r_vs1    <= (r_v < I_v_sync) ? I_vs_pol : ~I_vs_pol;
      r_rgb1   <= w_rgb;
      O_de     <= r_de1;
      O_hs     <= r_hs1;
      O_vs     <= r_vs1;
      O_data_r <= r_rgb1[7:0];
      O_data_g <= r_rgb1[15:8];
      O_data_b <= r_rgb1[23:16];
    end
  end

endmodule
